// File: rtl/axis_rr_pick.sv
// axis_rr_pick: combinational round-robin priority encoder.
//   Returns the first asserted request at or after i_ptr, wrapping at COUNT.
// Ports:
//   i_req   - request vector, one bit per source
//   i_ptr   - index that has highest priority this cycle (must be < COUNT)
//   o_found - at least one request is asserted
//   o_index - winning source index (valid only when o_found)
module axis_rr_pick #(
  parameter int COUNT     = 4,
  parameter int SEL_WIDTH = $clog2(COUNT)
) (
  input  logic [COUNT-1:0]     i_req,
  input  logic [SEL_WIDTH-1:0] i_ptr,
  output logic                 o_found,
  output logic [SEL_WIDTH-1:0] o_index
);

  logic [COUNT-1:0]     w_rot;
  logic [SEL_WIDTH-1:0] w_off;
  logic [SEL_WIDTH:0]   w_sum;

  // Rotate so that source i_ptr lands at bit 0; the doubled vector supplies
  // the wrapped-around bits.
  assign w_rot = COUNT'({i_req, i_req} >> i_ptr);

  // Lowest set bit of the rotated vector (scan downwards, last hit wins).
  always_comb begin
    o_found = 1'b0;
    w_off   = '0;
    for (int k = COUNT - 1; k >= 0; k--) begin
      if (w_rot[k]) begin
        o_found = 1'b1;
        w_off   = SEL_WIDTH'(k);
      end
    end
  end

  // Undo the rotation modulo COUNT; COUNT need not be a power of two, so the
  // wrap is done explicitly rather than by letting the adder overflow.
  always_comb begin
    w_sum = {1'b0, w_off} + {1'b0, i_ptr};
    if (w_sum >= (SEL_WIDTH + 1)'(COUNT)) begin
      w_sum = w_sum - (SEL_WIDTH + 1)'(COUNT);
    end
    o_index = w_sum[SEL_WIDTH-1:0];
  end

endmodule

// File: rtl/axis_arbiter.sv
// axis_arbiter: merges COUNT AXI-stream inputs into one output stream with
//   packet-aware round-robin arbitration. A source that wins keeps the grant
//   until its last beat has been accepted. The output is a single registered
//   stage.
// Ports:
//   clock, resetn - clock (rising edge), asynchronous active-low reset
//   idata  - COUNT packed beats, input k at [k*WIDTH +: WIDTH]
//   ivalid - per-input valid
//   ilast  - per-input end-of-packet flag
//   iready - per-input ready (combinational)
//   odata, olast, osel, ovalid - registered output beat, its source index
//   oready - downstream ready
module axis_arbiter #(
  parameter int WIDTH     = 8,
  parameter int COUNT     = 4,
  parameter int SEL_WIDTH = $clog2(COUNT)
) (
  input  logic                   clock,
  input  logic                   resetn,
  input  logic [COUNT*WIDTH-1:0] idata,
  input  logic [COUNT-1:0]       ivalid,
  input  logic [COUNT-1:0]       ilast,
  output logic [COUNT-1:0]       iready,
  output logic [WIDTH-1:0]       odata,
  output logic                   olast,
  output logic [SEL_WIDTH-1:0]   osel,
  output logic                   ovalid,
  input  logic                   oready
);

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } state_t;

  state_t               r_state;
  logic [SEL_WIDTH-1:0] r_grant;
  logic [SEL_WIDTH-1:0] r_ptr;
  logic [WIDTH-1:0]     r_odata;
  logic                 r_olast;
  logic [SEL_WIDTH-1:0] r_osel;
  logic                 r_ovalid;

  logic [WIDTH-1:0]     w_in [COUNT];
  logic                 w_found;
  logic [SEL_WIDTH-1:0] w_pick;
  logic [SEL_WIDTH-1:0] w_sel;
  logic [SEL_WIDTH-1:0] w_ptr_nx;
  logic                 w_space;
  logic                 w_have;
  logic                 w_xfer;

  always_comb begin
    for (int k = 0; k < COUNT; k++) begin
      w_in[k] = idata[k*WIDTH +: WIDTH];
    end
  end

  axis_rr_pick #(
    .COUNT    (COUNT),
    .SEL_WIDTH(SEL_WIDTH)
  ) u_pick (
    .i_req  (ivalid),
    .i_ptr  (r_ptr),
    .o_found(w_found),
    .o_index(w_pick)
  );

  // The output register can take a beat when empty or when it drains now.
  assign w_space = !r_ovalid || oready;

  // While locked the granted source is served even if it is momentarily
  // idle, so no other source can slip into the middle of a packet.
  assign w_sel  = (r_state == LOCKED) ? r_grant : w_pick;
  assign w_have = (r_state == LOCKED) || w_found;
  assign iready = (w_have && w_space) ? ({{(COUNT-1){1'b0}}, 1'b1} << w_sel) : '0;
  assign w_xfer = w_have && w_space && ivalid[w_sel];

  assign w_ptr_nx = (w_sel == SEL_WIDTH'(COUNT - 1)) ? '0 : w_sel + 1'b1;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_state  <= IDLE;
      r_grant  <= '0;
      r_ptr    <= '0;
      r_odata  <= '0;
      r_olast  <= 1'b0;
      r_osel   <= '0;
      r_ovalid <= 1'b0;
    end else if (w_xfer) begin
      r_odata  <= w_in[w_sel];
      r_olast  <= ilast[w_sel];
      r_osel   <= w_sel;
      r_ovalid <= 1'b1;
      if (ilast[w_sel]) begin
        // Fairness moves only at packet boundaries.
        r_state <= IDLE;
        r_ptr   <= w_ptr_nx;
      end else begin
        r_state <= LOCKED;
        r_grant <= w_sel;
      end
    end else if (oready) begin
      r_ovalid <= 1'b0;
    end
  end

  assign odata  = r_odata;
  assign olast  = r_olast;
  assign osel   = r_osel;
  assign ovalid = r_ovalid;

endmodule

// File: tb/tb_axis_arbiter.sv
// tb_axis_arbiter: directed scenarios followed by a randomized soak checked
//   against a behavioural model of the arbitration rules.
module tb_axis_arbiter;
  localparam int WIDTH = 8;
  localparam int COUNT = 4;
  localparam int SW    = 2;

  logic                   clock  = 1'b0;
  logic                   resetn = 1'b0;
  logic [COUNT*WIDTH-1:0] idata  = '0;
  logic [COUNT-1:0]       ivalid = '0;
  logic [COUNT-1:0]       ilast  = '0;
  logic [COUNT-1:0]       iready;
  logic [WIDTH-1:0]       odata;
  logic                   olast;
  logic [SW-1:0]          osel;
  logic                   ovalid;
  logic                   oready = 1'b1;

  int total = 0;
  int bad   = 0;

  always #5 clock = ~clock;

  axis_arbiter #(.WIDTH(WIDTH), .COUNT(COUNT), .SEL_WIDTH(SW)) dut (
    .clock (clock),
    .resetn(resetn),
    .idata (idata),
    .ivalid(ivalid),
    .ilast (ilast),
    .iready(iready),
    .odata (odata),
    .olast (olast),
    .osel  (osel),
    .ovalid(ovalid),
    .oready(oready)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic setd(input int k, input logic [7:0] v);
    idata[k*WIDTH +: WIDTH] = v;
  endtask

  task automatic chk_out(input string tag, input logic v, input logic [7:0] d,
                         input logic [1:0] s, input logic l);
    chk({tag, ".ovalid"}, ovalid, v);
    chk({tag, ".odata"},  odata,  d);
    chk({tag, ".osel"},   osel,   s);
    chk({tag, ".olast"},  olast,  l);
  endtask

  // Model state for the soak.
  int         mptr, owner, oown;
  logic       mv, ml;
  logic [7:0] md;
  logic [1:0] ms;
  int         cnt [COUNT];

  task automatic run_soak(input int n, input bit allv);
    int         ent, j, mn, mx;
    bit         space, ov, ol, orr;
    logic [1:0] os;
    logic [3:0] expr;
    resetn = 1'b0;
    ivalid = '0;
    tick();
    resetn = 1'b1;
    mptr = 0; owner = -1; oown = -1;
    mv = 1'b0; ml = 1'b0; md = '0; ms = '0;
    for (int k = 0; k < COUNT; k++) cnt[k] = 0;
    for (int c = 0; c < n; c++) begin
      ivalid = allv ? 4'hF : 4'($urandom);
      for (int k = 0; k < COUNT; k++) begin
        ilast[k] = ($urandom_range(0, 2) == 0);
        setd(k, 8'($urandom));
      end
      oready = ($urandom_range(0, 3) != 0);
      #1;
      space = !mv || oready;
      ent = -1;
      if (owner >= 0) ent = owner;
      else begin
        for (int d = 0; d < COUNT; d++) begin
          j = (mptr + d) % COUNT;
          if (ent < 0 && ivalid[j]) ent = j;
        end
      end
      expr = (ent >= 0 && space) ? (4'b0001 << ent) : 4'b0000;
      chk("soak.iready", iready, expr);
      ov = ovalid; os = osel; ol = olast; orr = oready;
      if (ent >= 0 && space && ivalid[ent]) begin
        md = idata[ent*WIDTH +: WIDTH];
        ml = ilast[ent];
        ms = 2'(ent);
        mv = 1'b1;
        if (ml) begin
          owner = -1;
          mptr  = (ent + 1) % COUNT;
        end else begin
          owner = ent;
        end
      end else if (oready) begin
        mv = 1'b0;
      end
      tick();
      chk("soak.ovalid", ovalid, mv);
      if (mv) begin
        chk("soak.odata", odata, md);
        chk("soak.osel",  osel,  ms);
        chk("soak.olast", olast, ml);
      end
      if (ov && orr) begin
        if (oown >= 0) chk("soak.interleave", os, oown);
        if (ol) begin
          cnt[os]++;
          oown = -1;
        end else if (oown < 0) begin
          oown = os;
        end
      end
    end
    if (allv) begin
      mn = cnt[0]; mx = cnt[0];
      for (int k = 1; k < COUNT; k++) begin
        if (cnt[k] < mn) mn = cnt[k];
        if (cnt[k] > mx) mx = cnt[k];
      end
      chk("soak.fair", (mx - mn <= 1), 1);
      chk("soak.some_packets", (mn > 100), 1);
    end
  endtask

  initial begin
    // Reset state
    #12;
    chk_out("reset", 1'b0, 8'h00, 2'd0, 1'b0);
    chk("reset.iready", iready, 4'b0000);
    tick();

    // Alternating single-beat packets from inputs 0 and 2
    resetn = 1'b1;
    ivalid = 4'b0101;
    ilast  = 4'b1111;
    setd(0, 8'h0A);
    setd(2, 8'h2A);
    #1;
    chk("rr.iready", iready, 4'b0001);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk_out("rr", 1'b1, (i % 2) ? 8'h2A : 8'h0A, (i % 2) ? 2'd2 : 2'd0, 1'b1);
    end
    ivalid = '0;
    tick();
    chk("idle.ovalid", ovalid, 1'b0);
    ivalid = 4'b0001;
    tick();
    chk("prime.osel", osel, 2'd0);

    // Locking: 3-beat packet on input 1 while input 0 waits
    ivalid = 4'b0011;
    ilast  = 4'b0001;
    setd(0, 8'h05);
    setd(1, 8'h11);
    #1;
    chk("lock.iready1", iready, 4'b0010);
    tick();
    chk_out("lock.b1", 1'b1, 8'h11, 2'd1, 1'b0);
    setd(1, 8'h12);
    #1;
    chk("lock.iready2", iready, 4'b0010);
    tick();
    chk_out("lock.b2", 1'b1, 8'h12, 2'd1, 1'b0);
    setd(1, 8'h13);
    ilast = 4'b0011;
    #1;
    chk("lock.iready3", iready, 4'b0010);
    tick();
    chk_out("lock.b3", 1'b1, 8'h13, 2'd1, 1'b1);
    setd(1, 8'h14);
    #1;
    chk("lock.after_iready", iready, 4'b0001);
    tick();
    chk_out("lock.next", 1'b1, 8'h05, 2'd0, 1'b1);

    // Gap inside a packet on input 3
    ivalid = 4'b0100;
    ilast  = 4'b0100;
    setd(2, 8'h22);
    tick();
    chk("gap.prime_osel", osel, 2'd2);
    ivalid = 4'b1011;
    ilast  = 4'b0011;
    setd(0, 8'h01);
    setd(1, 8'h02);
    setd(3, 8'hA0);
    #1;
    chk("gap.iready0", iready, 4'b1000);
    tick();
    chk_out("gap.first", 1'b1, 8'hA0, 2'd3, 1'b0);
    ivalid = 4'b0011;
    for (int g = 0; g < 3; g++) begin
      #1;
      chk("gap.iready", iready, 4'b1000);
      tick();
      chk("gap.ovalid", ovalid, 1'b0);
    end
    ivalid = 4'b1011;
    ilast  = 4'b1011;
    setd(3, 8'hA1);
    tick();
    chk_out("gap.last", 1'b1, 8'hA1, 2'd3, 1'b1);
    ivalid = 4'b0011;
    #1;
    chk("gap.wrap_iready", iready, 4'b0001);
    tick();
    chk_out("gap.wrap", 1'b1, 8'h01, 2'd0, 1'b1);

    // Backpressure
    ivalid = 4'b0100;
    ilast  = 4'b0100;
    setd(2, 8'h30);
    tick();
    chk_out("bp.load", 1'b1, 8'h30, 2'd2, 1'b1);
    oready = 1'b0;
    setd(2, 8'h31);
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("bp.iready", iready, 4'b0000);
      tick();
      chk_out("bp.hold", 1'b1, 8'h30, 2'd2, 1'b1);
    end
    oready = 1'b1;
    #1;
    chk("bp.release_iready", iready, 4'b0100);
    tick();
    chk_out("bp.next", 1'b1, 8'h31, 2'd2, 1'b1);

    // Reset in the middle of a packet from input 2
    ilast = 4'b0000;
    setd(2, 8'h40);
    tick();
    chk_out("rst.lock", 1'b1, 8'h40, 2'd2, 1'b0);
    #2;
    resetn = 1'b0;
    #1;
    chk_out("rst.async", 1'b0, 8'h00, 2'd0, 1'b0);
    tick();
    tick();
    resetn = 1'b1;
    ivalid = 4'b1100;
    ilast  = 4'b1100;
    setd(2, 8'h50);
    setd(3, 8'h60);
    #1;
    chk("rst.iready", iready, 4'b0100);
    tick();
    chk_out("rst.first", 1'b1, 8'h50, 2'd2, 1'b1);
    tick();
    chk_out("rst.second", 1'b1, 8'h60, 2'd3, 1'b1);

    // Randomized soak: sparse requests, then all inputs requesting
    run_soak(3000, 1'b0);
    run_soak(10000, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
